// File: rtl/axi_outstanding_limiter_pkg.sv
// axi_outstanding_limiter_pkg: state encoding, constants and default AXI channel types for the limiter
package axi_outstanding_limiter_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam int StallCntWidth = 32;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } default_aw_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } default_w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } default_b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } default_ar_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } default_r_chan_t;

    typedef struct packed {
        default_aw_chan_t aw;
        logic             aw_valid;
        default_w_chan_t  w;
        logic             w_valid;
        logic             b_ready;
        default_ar_chan_t ar;
        logic             ar_valid;
        logic             r_ready;
    } default_req_t;

    typedef struct packed {
        logic            aw_ready;
        logic            ar_ready;
        logic            w_ready;
        default_b_chan_t b;
        logic            b_valid;
        default_r_chan_t r;
        logic            r_valid;
    } default_resp_t;

endpackage

// File: rtl/axi_outstanding_limiter_txn_counter.sv
// axi_txn_counter: up/down count of in-flight transactions with full and underflow flags
module axi_txn_counter #(
    parameter int MaxCnt   = 4,
    parameter int CntWidth = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                full_o,
    output logic                underflow_o
);

    logic [CntWidth-1:0] r_cnt;
    logic                w_up;
    logic                w_dn;

    assign w_up        = inc_i & ~dec_i;
    assign w_dn        = dec_i & ~inc_i & (r_cnt != '0);
    assign underflow_o = dec_i & ~inc_i & (r_cnt == '0);
    assign full_o      = r_cnt == CntWidth'(MaxCnt);
    assign cnt_o       = r_cnt;

    // accept adds one, retire removes one, a simultaneous pair cancels; a retire at zero is dropped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     r_cnt <= '0;
        else if (w_up) r_cnt <= r_cnt + 1'b1;
        else if (w_dn) r_cnt <= r_cnt - 1'b1;
    end

endmodule

// File: rtl/axi_outstanding_limiter.sv
// axi_outstanding_limiter: caps in-flight AXI writes/reads and offers a flush/drain handshake.
// Optional limit-stall cycle counters are built when AXI_OUTSTANDING_LIMITER_STALL_CNT_EN is defined.
module axi_outstanding_limiter
    import axi_outstanding_limiter_pkg::*;
#(
    parameter type aw_chan_t = default_aw_chan_t,
    parameter type w_chan_t  = default_w_chan_t,
    parameter type b_chan_t  = default_b_chan_t,
    parameter type ar_chan_t = default_ar_chan_t,
    parameter type r_chan_t  = default_r_chan_t,
    parameter type req_t     = default_req_t,
    parameter type resp_t    = default_resp_t,
    parameter int  MaxWrTxns = 4,
    parameter int  MaxRdTxns = 4,
    localparam int CntWidth  = $clog2(((MaxWrTxns > MaxRdTxns) ? MaxWrTxns : MaxRdTxns) + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    output logic                     idle_o,
    output logic [CntWidth-1:0]      wr_outstanding_o,
    output logic [CntWidth-1:0]      rd_outstanding_o,
    input  req_t                     slv_req_i,
    output resp_t                    slv_resp_o,
    output req_t                     mst_req_o,
    input  resp_t                    mst_resp_i,
    output logic [StallCntWidth-1:0] aw_stall_cnt_o,
    output logic [StallCntWidth-1:0] ar_stall_cnt_o
);

    state_e              r_state;
    logic                r_idle;
    logic [CntWidth-1:0] w_wr_cnt;
    logic [CntWidth-1:0] w_rd_cnt;
    logic                w_wr_full;
    logic                w_rd_full;
    logic                w_wr_underflow;
    logic                w_rd_underflow;
    logic                w_aw_allow;
    logic                w_ar_allow;
    logic                w_aw_hs;
    logic                w_b_hs;
    logic                w_ar_hs;
    logic                w_r_last_hs;
    aw_chan_t            w_aw;
    w_chan_t             w_w;
    b_chan_t             w_b;
    ar_chan_t            w_ar;
    r_chan_t             w_r;

    // gates come from registered state only, so a retire opens the gate one cycle later
    assign w_aw_allow  = (r_state == RUN) & ~w_wr_full;
    assign w_ar_allow  = (r_state == RUN) & ~w_rd_full;
    assign w_aw_hs     = slv_req_i.aw_valid & mst_resp_i.aw_ready & w_aw_allow;
    assign w_ar_hs     = slv_req_i.ar_valid & mst_resp_i.ar_ready & w_ar_allow;
    assign w_b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign w_r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

    assign w_aw = slv_req_i.aw;
    assign w_w  = slv_req_i.w;
    assign w_ar = slv_req_i.ar;
    assign w_b  = mst_resp_i.b;
    assign w_r  = mst_resp_i.r;

    // downstream request: payloads straight through, only AW/AR valid gated
    always_comb begin
        mst_req_o.aw       = w_aw;
        mst_req_o.aw_valid = slv_req_i.aw_valid & w_aw_allow;
        mst_req_o.w        = w_w;
        mst_req_o.w_valid  = slv_req_i.w_valid;
        mst_req_o.b_ready  = slv_req_i.b_ready;
        mst_req_o.ar       = w_ar;
        mst_req_o.ar_valid = slv_req_i.ar_valid & w_ar_allow;
        mst_req_o.r_ready  = slv_req_i.r_ready;
    end

    // upstream response: payloads straight through, only AW/AR ready gated
    always_comb begin
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & w_aw_allow;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & w_ar_allow;
        slv_resp_o.w_ready  = mst_resp_i.w_ready;
        slv_resp_o.b        = w_b;
        slv_resp_o.b_valid  = mst_resp_i.b_valid;
        slv_resp_o.r        = w_r;
        slv_resp_o.r_valid  = mst_resp_i.r_valid;
    end

    axi_txn_counter #(
        .MaxCnt   (MaxWrTxns),
        .CntWidth (CntWidth)
    ) u_wr_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inc_i       (w_aw_hs),
        .dec_i       (w_b_hs),
        .cnt_o       (w_wr_cnt),
        .full_o      (w_wr_full),
        .underflow_o (w_wr_underflow)
    );

    axi_txn_counter #(
        .MaxCnt   (MaxRdTxns),
        .CntWidth (CntWidth)
    ) u_rd_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inc_i       (w_ar_hs),
        .dec_i       (w_r_last_hs),
        .cnt_o       (w_rd_cnt),
        .full_o      (w_rd_full),
        .underflow_o (w_rd_underflow)
    );

    // flush sequencing: RUN -> DRAIN until empty -> HALTED; idle is registered alongside the state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= RUN;
            r_idle  <= 1'b0;
        end else begin
            case (r_state)
                RUN: if (flush_i) r_state <= DRAIN;
                DRAIN: begin
                    if (!flush_i) r_state <= RUN;
                    else if (w_wr_cnt == '0 && w_rd_cnt == '0) begin
                        r_state <= HALTED;
                        r_idle  <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!flush_i) begin
                        r_state <= RUN;
                        r_idle  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_idle  <= 1'b0;
                end
            endcase
        end
    end

    assign idle_o           = r_idle;
    assign wr_outstanding_o = w_wr_cnt;
    assign rd_outstanding_o = w_rd_cnt;

`ifdef AXI_OUTSTANDING_LIMITER_STALL_CNT_EN
    logic [StallCntWidth-1:0] r_aw_stall;
    logic [StallCntWidth-1:0] r_ar_stall;

    // count only cycles lost to the outstanding limit, saturating; drain blocking is not counted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_aw_stall <= '0;
            r_ar_stall <= '0;
        end else begin
            if (slv_req_i.aw_valid && r_state == RUN && w_wr_full && r_aw_stall != '1)
                r_aw_stall <= r_aw_stall + 1'b1;
            if (slv_req_i.ar_valid && r_state == RUN && w_rd_full && r_ar_stall != '1)
                r_ar_stall <= r_ar_stall + 1'b1;
        end
    end

    assign aw_stall_cnt_o = r_aw_stall;
    assign ar_stall_cnt_o = r_ar_stall;
`else
    assign aw_stall_cnt_o = '0;
    assign ar_stall_cnt_o = '0;
`endif

    a_wr_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !w_wr_underflow);
    a_rd_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !w_rd_underflow);

endmodule
